// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two 2-entry request FIFOs drained round-robin
// into a single registered write port (Waddr/WD/En).
module rf_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          A_Valid,
  input  logic [AW-1:0] A_Addr,
  input  logic [DW-1:0] A_Data,
  output logic          A_Ready,
  input  logic          B_Valid,
  input  logic [AW-1:0] B_Addr,
  input  logic [DW-1:0] B_Data,
  output logic          B_Ready,
  output logic [AW-1:0] Waddr,
  output logic [DW-1:0] WD,
  output logic          En,
  output logic          Busy
);

  localparam int EW = AW + DW;

  // Index 0 is requester A, index 1 is requester B.
  logic [1:0]    valid;
  logic [1:0]    ready;
  logic [1:0]    nonempty;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [EW-1:0] entry_in [2];
  logic [EW-1:0] head     [2];

  assign valid       = {B_Valid, A_Valid};
  assign entry_in[0] = {A_Addr, A_Data};
  assign entry_in[1] = {B_Addr, B_Data};
  assign push        = valid & ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [EW-1:0] mem_q [2];
      logic [EW-1:0] mem_d [2];
      logic          wr_q, wr_d;
      logic          rd_q, rd_d;
      logic [1:0]    cnt_q, cnt_d;

      always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push[gi]) begin
          mem_d[wr_q] = entry_in[gi];
          wr_d        = ~wr_q;
        end
        if (pop[gi]) begin
          rd_d = ~rd_q;
        end
        cnt_d = cnt_q + {1'b0, push[gi]} - {1'b0, pop[gi]};
        if (Reset) begin
          wr_d  = 1'b0;
          rd_d  = 1'b0;
          cnt_d = 2'd0;
        end
      end

      always_ff @(posedge Clk) begin
        mem_q <= mem_d;
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end

      // Readiness looks only at start-of-cycle occupancy, so a full FIFO
      // refuses a push even in the cycle it is being popped.
      assign ready[gi]    = (cnt_q != 2'd2) && !Reset;
      assign nonempty[gi] = (cnt_q != 2'd0);
      assign head[gi]     = mem_q[rd_q];
    end
  endgenerate

  logic          last_b_q, last_b_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          en_q, en_d;
  logic [EW-1:0] sel_entry;

  always_comb begin
    pop = 2'b00;
    if (!Reset) begin
      case (nonempty)
        2'b01:   pop = 2'b01;
        2'b10:   pop = 2'b10;
        2'b11:   pop = last_b_q ? 2'b01 : 2'b10;
        default: pop = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_b_d  = last_b_q;
    waddr_d   = waddr_q;
    wd_d      = wd_q;
    en_d      = 1'b0;
    sel_entry = pop[1] ? head[1] : head[0];
    if (pop != 2'b00) begin
      last_b_d = pop[1];
      // A zero destination is consumed silently: the port is cleared, no write.
      if (sel_entry[EW-1:DW] != '0) begin
        waddr_d = sel_entry[EW-1:DW];
        wd_d    = sel_entry[DW-1:0];
        en_d    = 1'b1;
      end else begin
        waddr_d = '0;
        wd_d    = '0;
      end
    end
    if (Reset) begin
      last_b_d = 1'b1;
      waddr_d  = '0;
      wd_d     = '0;
      en_d     = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    last_b_q <= last_b_d;
    waddr_q  <= waddr_d;
    wd_q     <= wd_d;
    en_q     <= en_d;
  end

  assign A_Ready = ready[0];
  assign B_Ready = ready[1];
  assign Waddr   = waddr_q;
  assign WD      = wd_q;
  assign En      = en_q;
  assign Busy    = (|nonempty) || en_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a cycle-by-cycle vector table followed by
// a streaming sequence checking per-requester write order.
module tb_rf_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        A_Valid, B_Valid;
  logic [4:0]  A_Addr, B_Addr;
  logic [31:0] A_Data, B_Data;
  logic        A_Ready, B_Ready;
  logic [4:0]  Waddr;
  logic [31:0] WD;
  logic        En, Busy;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.DW(32), .AW(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .A_Valid(A_Valid), .A_Addr(A_Addr), .A_Data(A_Data), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_Addr(B_Addr), .B_Data(B_Data), .B_Ready(B_Ready),
    .Waddr(Waddr), .WD(WD), .En(En), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ar;
    logic        br;
    logic        en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic v(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                   input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                   input logic ar, input logic br, input logic en, input logic [4:0] wa,
                   input logic [31:0] wd, input logic busy);
    vec_t r;
    r = '{rst, av, aa, ad, bv, ba, bd, ar, br, en, wa, wd, busy};
    vq.push_back(r);
  endtask

  logic [31:0] a_wr[$];
  logic [31:0] b_wr[$];
  logic [31:0] act;

  initial begin
    //  rst av aa  ad            bv ba  bd        | ar br en wa  wd             busy
    // single write
    v(1, 0, 0, 0,            0, 0, 0,          0, 0, 0, 0,  0,            0);
    v(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,          1, 1, 0, 0,  0,            0);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 0, 0,  0,            1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 1, 5,  32'hDEADBEEF, 1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 0, 5,  32'hDEADBEEF, 0);
    // tie after reset, then alternation; B push refused while full
    v(1, 0, 0, 0,            0, 0, 0,          0, 0, 0, 5,  32'hDEADBEEF, 0);
    v(0, 1, 3, 32'h11,       1, 4, 32'h22,     1, 1, 0, 0,  0,            0);
    v(0, 1, 6, 32'h33,       1, 7, 32'h44,     1, 1, 0, 0,  0,            1);
    v(0, 1, 8, 32'h55,       1, 9, 32'h66,     1, 0, 1, 3,  32'h11,       1);
    v(0, 0, 0, 0,            0, 0, 0,          0, 1, 1, 4,  32'h22,       1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 1, 6,  32'h33,       1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 1, 7,  32'h44,       1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 1, 8,  32'h55,       1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 0, 8,  32'h55,       0);
    // zero address
    v(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,          1, 1, 0, 8,  32'h55,       0);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 0, 8,  32'h55,       1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 0, 0,  0,            0);
    // full A FIFO refuses push while popping, accepts next cycle
    v(0, 1, 10, 32'hA1,      1, 11, 32'hB1,    1, 1, 0, 0,  0,            0);
    v(0, 1, 12, 32'hA2,      1, 13, 32'hB2,    1, 1, 0, 0,  0,            1);
    v(0, 1, 14, 32'hA3,      0, 0, 0,          0, 1, 1, 11, 32'hB1,       1);
    v(0, 1, 14, 32'hA3,      0, 0, 0,          1, 1, 1, 10, 32'hA1,       1);
    v(0, 0, 0, 0,            0, 0, 0,          0, 1, 1, 13, 32'hB2,       1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 1, 12, 32'hA2,       1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 1, 14, 32'hA3,       1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 0, 14, 32'hA3,       0);
    // B alone streaming: ready stays high
    v(0, 0, 0, 0,            1, 1, 32'hB01,    1, 1, 0, 14, 32'hA3,       0);
    v(0, 0, 0, 0,            1, 2, 32'hB02,    1, 1, 0, 14, 32'hA3,       1);
    v(0, 0, 0, 0,            1, 3, 32'hB03,    1, 1, 1, 1,  32'hB01,      1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 1, 2,  32'hB02,      1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 1, 3,  32'hB03,      1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 0, 3,  32'hB03,      0);
    // reset mid-stream with entries buffered and pushes pending
    v(0, 1, 20, 32'hC1,      1, 21, 32'hD1,    1, 1, 0, 3,  32'hB03,      0);
    v(0, 1, 22, 32'hC2,      1, 23, 32'hD2,    1, 1, 0, 3,  32'hB03,      1);
    v(0, 1, 24, 32'hC3,      1, 25, 32'hD3,    1, 0, 1, 20, 32'hC1,       1);
    v(1, 1, 26, 32'hC4,      1, 27, 32'hD4,    0, 0, 1, 21, 32'hD1,       1);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 0, 0,  0,            0);
    v(0, 0, 0, 0,            0, 0, 0,          1, 1, 0, 0,  0,            0);

    Reset = 1'b1; A_Valid = 1'b0; B_Valid = 1'b0;
    A_Addr = '0; A_Data = '0; B_Addr = '0; B_Data = '0;
    repeat (2) @(posedge Clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge Clk);
      Reset = vq[i].rst;
      A_Valid = vq[i].av; A_Addr = vq[i].aa; A_Data = vq[i].ad;
      B_Valid = vq[i].bv; B_Addr = vq[i].ba; B_Data = vq[i].bd;
      #1;
      chk("A_Ready", i, {31'd0, A_Ready}, {31'd0, vq[i].ar});
      chk("B_Ready", i, {31'd0, B_Ready}, {31'd0, vq[i].br});
      chk("En",      i, {31'd0, En},      {31'd0, vq[i].en});
      chk("Waddr",   i, {27'd0, Waddr},   {27'd0, vq[i].wa});
      chk("WD",      i, WD,               vq[i].wd);
      chk("Busy",    i, {31'd0, Busy},    {31'd0, vq[i].busy});
      $display("row %0d: rst=%0b A=%0b B=%0b -> En=%0b Waddr=%0d WD=%h Busy=%0b",
               i, vq[i].rst, vq[i].av, vq[i].bv, En, Waddr, WD, Busy);
    end

    // Streaming: A sends 4 entries, B sends data 1,2,3 holding valid until accepted.
    begin
      int ai, bi;
      ai = 0; bi = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge Clk);
        Reset = 1'b0;
        if (En) begin
          if (Waddr >= 5'd16) b_wr.push_back(WD);
          else                a_wr.push_back(WD);
          $display("stream cycle %0d: write Waddr=%0d WD=%0d", cyc, Waddr, WD);
        end
        A_Valid = (ai < 4); A_Addr = 5'(ai + 1);  A_Data = 32'(100 + ai);
        B_Valid = (bi < 3); B_Addr = 5'(bi + 16); B_Data = 32'(bi + 1);
        if (A_Valid && A_Ready) ai++;
        if (B_Valid && B_Ready) bi++;
      end
      A_Valid = 1'b0; B_Valid = 1'b0;
      chk("stream_a_count", 0, a_wr.size(), 4);
      chk("stream_b_count", 0, b_wr.size(), 3);
      for (int i = 0; i < 4; i++) begin
        act = (i < a_wr.size()) ? a_wr[i] : 32'hFFFF_FFFF;
        chk("stream_a_order", i, act, 32'(100 + i));
      end
      for (int i = 0; i < 3; i++) begin
        act = (i < b_wr.size()) ? b_wr[i] : 32'hFFFF_FFFF;
        chk("stream_b_order", i, act, 32'(i + 1));
      end
      #1;
      chk("stream_idle_busy", 0, {31'd0, Busy}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
